bit_stuffer_stream: RTL and testbench
=====================================

Name: bit_stuffer_stream

Overview:
- Parametrised, flow-controlled successor to the team's fixed USB bit stuffer.
- Accepts a serial bitstream on a valid/ready handshake. After every RUN_LEN consecutive 1s it inserts one STUFF_BIT, stalling the upstream source for that cycle.
- Carries packet framing (last), and reports a per-packet stuff count.
- Sits between the packet serialiser and the line driver in the USB TX path.

Parameters:
- RUN_LEN, 6, number of consecutive 1s after which a stuff bit is inserted (legal range 2..15).
- STUFF_BIT, 1'b0, value of the inserted bit.
- CNT_W, 8, width of the per-packet stuff counter.

Ports:
- clk  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- in_bit  in  1  data bit
- in_valid  in  1  in_bit/in_last valid
- in_last  in  1  in_bit is the final bit of the packet
- in_ready  out  1  block accepts the input this cycle
- out_bit  out  1  stuffed data bit (line level when NRZI is enabled)
- out_valid  out  1  out_bit valid
- out_last  out  1  out_bit is the final bit of the stuffed packet
- out_ready  in  1  downstream accepts out_bit
- out_is_stuff  out  1  out_bit is an inserted stuff bit
- stuff_cnt  out  CNT_W  stuff bits inserted in the current/last packet, saturating

Behaviour:
- Reset values (async on nRST low):
  - out_valid=0, out_bit=0 (1 when NRZI is enabled), out_last=0, out_is_stuff=0.
  - stuff_cnt=0, internal run counter=0, stuff_pending=0, first-bit flag=1.
- Output is a single register stage. It is free when !out_valid or out_ready.
- in_ready = !stuff_pending && output stage free. The signal is combinational and does not depend on in_valid.
- Input transfer (in_valid && in_ready), latency 1 cycle:
  - Output register loads out_bit=in_bit, out_valid=1, out_is_stuff=0.
  - Run counter:
    - in_bit=1 increments the counter.
    - in_bit=0 clears the counter.
    - If the incremented count equals RUN_LEN, counter->0 and stuff_pending=1.
  - out_last=in_last only when no stuff is being scheduled. If in_last and stuff is scheduled, out_last=0 and the last flag is held with the pending stuff.
- Stuff insertion:
  - While stuff_pending, when the output stage is free: load out_bit=STUFF_BIT, out_is_stuff=1, out_valid=1, out_last=held last flag.
  - Then clear stuff_pending and increment stuff_cnt. The increment saturates at 2^CNT_W-1.
  - Stuff bits do not count toward the run, so the run counter stays 0.
- Output stage free with no transfer and no pending stuff: out_valid=0, and the other output fields hold.
- Backpressure (out_valid && !out_ready):
  - All output fields hold stable.
  - in_ready=0.
  - No state changes.
- Packet boundaries:
  - On the first input transfer of a packet (first-bit flag=1), stuff_cnt resets to 0 in the same cycle, then counts that packet's stuffs. The first-bit flag then clears.
  - When the final bit (out_last=1) is transferred downstream: run counter=0 and first-bit flag=1.
  - stuff_cnt holds its value until the next packet's first bit.
- Bit order: the run counter uses only in_bit values. An all-ones input of N bits produces floor(N/RUN_LEN) stuff bits.
- A stuff bit for bit k is emitted before bit k+1 is accepted. There is exactly one stall cycle of in_ready per stuff when out_ready=1.
- Throughput: one bit per cycle when out_ready=1 and no stuff occurs.
- in_valid deasserting mid-packet does not reset the run counter. Gaps are transparent.
- Reset mid-packet: all state returns to reset values immediately. Pending stuff is discarded.

Optional Feature:
- Macro: BIT_STUFFER_STREAM_NRZI_EN
- Defined: out_bit is the NRZI line level.
  - A level register is updated whenever a new bit is loaded into the output stage: bit 0 toggles the level, bit 1 holds it.
  - Stuff bits are encoded the same way.
  - The level register resets to 1 (J/idle).
  - The level returns to 1 in the cycle after an out_last transfer.
  - out_is_stuff and stuff_cnt are unchanged.
- Undefined: out_bit is the raw stuffed data. No level register exists.

Test Plan:
- Bits 1,1,1,1,1,1,0 with last on the final 0, out_ready=1, RUN_LEN=6 -> output 1,1,1,1,1,1,0(stuff),0(last):
  - out_is_stuff=1 on the 7th output bit.
  - in_ready low for exactly 1 cycle after the 6th 1.
  - stuff_cnt=1.
- 13 consecutive 1s, last on the 13th -> 15 output bits with stuffs at output positions 7 and 14; last on position 15; stuff_cnt=2.
- 12 consecutive 1s with last on the 12th -> 14 outputs; the final output is the stuff bit carrying out_last=1; the next packet starts with run=0 and stuff_cnt reset on its first bit.
- Pattern 1,1,1,1,1,0,1,1,1,1,1,1 with out_ready toggling 1,0,1,0 -> outputs are stable while stalled; exactly one stuff after the 12th bit; no bit lost or duplicated vs. a reference model.
- nRST pulsed low with stuff_pending=1 mid-packet -> all outputs at reset values; the following packet of 6 ones gets a stuff after the 6th bit (run not carried over).
- With BIT_STUFFER_STREAM_NRZI_EN, input 0,1,1,0,last -> line levels 0,0,0,1; the level returns to 1 after the last transfer.

Source files
------------

// File: rtl/bit_stuffer_stream.sv
`default_nettype none
// ============================================================================
// Module   : bit_stuffer_stream
// Purpose  : Valid/ready serial bit stuffer; inserts STUFF_BIT after RUN_LEN
//            consecutive ones, tracks packet framing and per-packet stuff count.
//            Optional NRZI line encoding: define BIT_STUFFER_STREAM_NRZI_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bit_stuffer_stream #(
    parameter int   RUN_LEN   = 6,
    parameter logic STUFF_BIT = 1'b0,
    parameter int   CNT_W     = 8
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             out_is_stuff,
    output logic [CNT_W-1:0] stuff_cnt
);

    localparam int                 c_RUN_W   = 4;
    localparam logic [c_RUN_W-1:0] c_RUN_LEN = c_RUN_W'(RUN_LEN);
    localparam logic [CNT_W-1:0]   c_CNT_MAX = '1;
`ifdef BIT_STUFFER_STREAM_NRZI_EN
    localparam logic               c_OUT_RST = 1'b1;
`else
    localparam logic               c_OUT_RST = 1'b0;
`endif

    logic               r_out_bit;
    logic               r_out_valid;
    logic               r_out_last;
    logic               r_out_is_stuff;
    logic [CNT_W-1:0]   r_stuff_cnt;
    logic [c_RUN_W-1:0] r_run;
    logic               r_stuff_pending;
    logic               r_held_last;
    logic               r_first;

    logic               w_stage_free;
    logic               w_in_xfer;
    logic               w_last_xfer;
    logic               w_load_stuff;
    logic               w_load_bit;
    logic               w_out_value;
    logic [c_RUN_W-1:0] w_run_base;
    logic [c_RUN_W-1:0] w_run_inc;
    logic               w_first_base;
    logic               w_hit;

    assign w_stage_free = !r_out_valid || out_ready;
    assign in_ready     = !r_stuff_pending && w_stage_free;
    assign w_in_xfer    = in_valid && in_ready;
    assign w_last_xfer  = r_out_valid && out_ready && r_out_last;
    assign w_load_stuff = w_stage_free && r_stuff_pending;
    assign w_load_bit   = w_load_stuff ? STUFF_BIT : in_bit;

    // A packet ending this cycle means a bit loaded now already belongs to the next one.
    assign w_run_base   = w_last_xfer ? '0 : r_run;
    assign w_first_base = w_last_xfer || r_first;
    assign w_run_inc    = w_run_base + c_RUN_W'(1);
    assign w_hit        = in_bit && (w_run_inc == c_RUN_LEN);

`ifdef BIT_STUFFER_STREAM_NRZI_EN
    logic r_level;
    logic w_level_base;

    assign w_level_base = w_last_xfer ? 1'b1 : r_level;
    assign w_out_value  = w_load_bit ? w_level_base : !w_level_base;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_level <= 1'b1;
        end else if (w_load_stuff || w_in_xfer) begin
            r_level <= w_out_value;
        end else begin
            r_level <= w_level_base;
        end
    end
`else
    assign w_out_value = w_load_bit;
`endif

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_out_bit       <= c_OUT_RST;
            r_out_valid     <= 1'b0;
            r_out_last      <= 1'b0;
            r_out_is_stuff  <= 1'b0;
            r_stuff_cnt     <= '0;
            r_run           <= '0;
            r_stuff_pending <= 1'b0;
            r_held_last     <= 1'b0;
            r_first         <= 1'b1;
        end else if (w_stage_free) begin
            r_run   <= w_run_base;
            r_first <= w_first_base;
            if (w_load_stuff) begin
                r_out_bit       <= w_out_value;
                r_out_valid     <= 1'b1;
                r_out_is_stuff  <= 1'b1;
                r_out_last      <= r_held_last;
                r_stuff_pending <= 1'b0;
                r_held_last     <= 1'b0;
                if (r_stuff_cnt != c_CNT_MAX) begin
                    r_stuff_cnt <= r_stuff_cnt + CNT_W'(1);
                end
            end else if (w_in_xfer) begin
                r_out_bit      <= w_out_value;
                r_out_valid    <= 1'b1;
                r_out_is_stuff <= 1'b0;
                r_first        <= 1'b0;
                if (w_first_base) begin
                    r_stuff_cnt <= '0;
                end
                if (!in_bit) begin
                    r_run      <= '0;
                    r_out_last <= in_last;
                end else if (w_hit) begin
                    // The packet's last flag travels with the stuff bit instead.
                    r_run           <= '0;
                    r_stuff_pending <= 1'b1;
                    r_held_last     <= in_last;
                    r_out_last      <= 1'b0;
                end else begin
                    r_run      <= w_run_inc;
                    r_out_last <= in_last;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_bit      = r_out_bit;
    assign out_valid    = r_out_valid;
    assign out_last     = r_out_last;
    assign out_is_stuff = r_out_is_stuff;
    assign stuff_cnt    = r_stuff_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bit_stuffer_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_stuffer_stream
// Purpose  : Directed self-checking bench for bit_stuffer_stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_stuffer_stream;

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready;
    logic       out_bit;
    logic       out_valid;
    logic       out_last;
    logic       out_is_stuff;
    logic [7:0] stuff_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] cap_data;
    logic [31:0] cap_stuff;
    logic [31:0] cap_last;
    int          cap_n;
    int          stalls;

`ifdef BIT_STUFFER_STREAM_NRZI_EN
    localparam logic c_BIT_RST = 1'b1;
`else
    localparam logic c_BIT_RST = 1'b0;
`endif

    always #5 clk = ~clk;

    bit_stuffer_stream dut (
        .clk(clk), .nRST(nRST),
        .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_bit(out_bit), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .out_is_stuff(out_is_stuff), .stuff_cnt(stuff_cnt)
    );

    // Expected line levels for a raw expected stream (level 1 at each packet start).
    function automatic logic [31:0] enc(input logic [31:0] raw, input logic [31:0] lst, input int n);
        logic        lvl;
        logic [31:0] r;
        lvl = 1'b1;
        r   = '0;
        for (int i = 0; i < n; i++) begin
            if (!raw[i]) lvl = ~lvl;
            r[i] = lvl;
            if (lst[i]) lvl = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_line(input logic [31:0] raw, input logic [31:0] lst, input int n);
`ifdef BIT_STUFFER_STREAM_NRZI_EN
        return enc(raw, lst, n);
`else
        if (n < 0) return '0;
        return raw & lst | raw;
`endif
    endfunction

    // Feeds n bits (index 0 first) and captures every downstream transfer.
    task automatic drive(input int n, input logic [31:0] bits, input logic [31:0] lasts, input bit toggle);
        int       idx = 0;
        int       cyc = 0;
        int       nlast = 0;
        int       seen = 0;
        bit       hold = 0;
        logic [3:0] prev = '0;
        for (int i = 0; i < n; i++) nlast += int'(lasts[i]);
        cap_data = '0; cap_stuff = '0; cap_last = '0; cap_n = 0; stalls = 0;
        while (!(idx >= n && seen >= nlast) && cyc < 300) begin
            @(negedge clk);
            in_valid  = (idx < n);
            in_bit    = (idx < n) ? bits[idx] : 1'b0;
            in_last   = (idx < n) ? lasts[idx] : 1'b0;
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (hold) begin
                n_checks++;
                if ({out_valid, out_bit, out_last, out_is_stuff} !== prev) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %b want %b", {out_valid, out_bit, out_last, out_is_stuff}, prev);
                end
            end
            if (out_valid && !out_ready) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_in_ready: got %b want 0", in_ready);
                end
            end
            if (in_valid && !in_ready && out_ready) stalls++;
            if (out_valid && out_ready && cap_n < 32) begin
                cap_data[cap_n]  = out_bit;
                cap_stuff[cap_n] = out_is_stuff;
                cap_last[cap_n]  = out_last;
                if (out_last) seen++;
                cap_n++;
            end
            hold = out_valid && !out_ready;
            prev = {out_valid, out_bit, out_last, out_is_stuff};
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        n_checks++;
        if (cyc >= 300) begin
            n_fail++;
            $display("FAIL drive_timeout: accepted %0d of %0d, lasts %0d of %0d", idx, n, seen, nlast);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        repeat (2) @(negedge clk);
        n_checks += 6;
        if (out_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        if (out_bit !== c_BIT_RST)  begin n_fail++; $display("FAIL rst_out_bit: got %b want %b", out_bit, c_BIT_RST); end
        if (out_last !== 1'b0)      begin n_fail++; $display("FAIL rst_out_last: got %b want 0", out_last); end
        if (out_is_stuff !== 1'b0)  begin n_fail++; $display("FAIL rst_is_stuff: got %b want 0", out_is_stuff); end
        if (stuff_cnt !== 8'd0)     begin n_fail++; $display("FAIL rst_stuff_cnt: got %0d want 0", stuff_cnt); end
        if (in_ready !== 1'b1)      begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        nRST = 1'b1;
    endtask

    task automatic test_single_stuff();
        logic [31:0] exp_d;
        drive(7, 32'h3F, 32'h40, 1'b0);
        exp_d = exp_line(32'h3F, 32'h80, 8);
        n_checks += 6;
        if (cap_n !== 8)            begin n_fail++; $display("FAIL t1_count: got %0d want 8", cap_n); end
        if (cap_data !== exp_d)     begin n_fail++; $display("FAIL t1_data: got %h want %h", cap_data, exp_d); end
        if (cap_stuff !== 32'h40)   begin n_fail++; $display("FAIL t1_stuff: got %h want 40", cap_stuff); end
        if (cap_last !== 32'h80)    begin n_fail++; $display("FAIL t1_last: got %h want 80", cap_last); end
        if (stalls !== 1)           begin n_fail++; $display("FAIL t1_stalls: got %0d want 1", stalls); end
        if (stuff_cnt !== 8'd1)     begin n_fail++; $display("FAIL t1_stuff_cnt: got %0d want 1", stuff_cnt); end
    endtask

    task automatic test_thirteen_ones();
        logic [31:0] exp_d;
        drive(13, 32'h1FFF, 32'h1000, 1'b0);
        exp_d = exp_line(32'h5FBF, 32'h4000, 15);
        n_checks += 6;
        if (cap_n !== 15)           begin n_fail++; $display("FAIL t13_count: got %0d want 15", cap_n); end
        if (cap_data !== exp_d)     begin n_fail++; $display("FAIL t13_data: got %h want %h", cap_data, exp_d); end
        if (cap_stuff !== 32'h2040) begin n_fail++; $display("FAIL t13_stuff: got %h want 2040", cap_stuff); end
        if (cap_last !== 32'h4000)  begin n_fail++; $display("FAIL t13_last: got %h want 4000", cap_last); end
        if (stalls !== 2)           begin n_fail++; $display("FAIL t13_stalls: got %0d want 2", stalls); end
        if (stuff_cnt !== 8'd2)     begin n_fail++; $display("FAIL t13_stuff_cnt: got %0d want 2", stuff_cnt); end
    endtask

    task automatic test_stuff_carries_last();
        logic [31:0] exp_d;
        drive(12, 32'hFFF, 32'h800, 1'b0);
        exp_d = exp_line(32'h1FBF, 32'h2000, 14);
        n_checks += 6;
        if (cap_n !== 14)           begin n_fail++; $display("FAIL t12_count: got %0d want 14", cap_n); end
        if (cap_data !== exp_d)     begin n_fail++; $display("FAIL t12_data: got %h want %h", cap_data, exp_d); end
        if (cap_stuff !== 32'h2040) begin n_fail++; $display("FAIL t12_stuff: got %h want 2040", cap_stuff); end
        if (cap_last !== 32'h2000)  begin n_fail++; $display("FAIL t12_last: got %h want 2000", cap_last); end
        if (stalls !== 1)           begin n_fail++; $display("FAIL t12_stalls: got %0d want 1", stalls); end
        if (stuff_cnt !== 8'd2)     begin n_fail++; $display("FAIL t12_stuff_cnt: got %0d want 2", stuff_cnt); end
        drive(4, 32'h7, 32'h8, 1'b0);
        exp_d = exp_line(32'h7, 32'h8, 4);
        n_checks += 4;
        if (cap_n !== 4)            begin n_fail++; $display("FAIL t12n_count: got %0d want 4", cap_n); end
        if (cap_data !== exp_d)     begin n_fail++; $display("FAIL t12n_data: got %h want %h", cap_data, exp_d); end
        if (cap_stuff !== 32'h0)    begin n_fail++; $display("FAIL t12n_stuff: got %h want 0", cap_stuff); end
        if (stuff_cnt !== 8'd0)     begin n_fail++; $display("FAIL t12n_stuff_cnt: got %0d want 0", stuff_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d;
        drive(7, 32'h7F, 32'h44, 1'b0);
        exp_d = exp_line(32'h7F, 32'h44, 7);
        n_checks += 5;
        if (cap_n !== 7)            begin n_fail++; $display("FAIL b2b_count: got %0d want 7", cap_n); end
        if (cap_data !== exp_d)     begin n_fail++; $display("FAIL b2b_data: got %h want %h", cap_data, exp_d); end
        if (cap_stuff !== 32'h0)    begin n_fail++; $display("FAIL b2b_stuff: got %h want 0", cap_stuff); end
        if (cap_last !== 32'h44)    begin n_fail++; $display("FAIL b2b_last: got %h want 44", cap_last); end
        if (stuff_cnt !== 8'd0)     begin n_fail++; $display("FAIL b2b_stuff_cnt: got %0d want 0", stuff_cnt); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d;
        drive(12, 32'hFDF, 32'h800, 1'b1);
        exp_d = exp_line(32'hFDF, 32'h1000, 13);
        n_checks += 5;
        if (cap_n !== 13)           begin n_fail++; $display("FAIL bp_count: got %0d want 13", cap_n); end
        if (cap_data !== exp_d)     begin n_fail++; $display("FAIL bp_data: got %h want %h", cap_data, exp_d); end
        if (cap_stuff !== 32'h1000) begin n_fail++; $display("FAIL bp_stuff: got %h want 1000", cap_stuff); end
        if (cap_last !== 32'h1000)  begin n_fail++; $display("FAIL bp_last: got %h want 1000", cap_last); end
        if (stuff_cnt !== 8'd1)     begin n_fail++; $display("FAIL bp_stuff_cnt: got %0d want 1", stuff_cnt); end
    endtask

    task automatic test_reset_mid_packet();
        logic [31:0] exp_d;
        drive(6, 32'h3F, 32'h0, 1'b0);
        n_checks++;
        if (in_ready !== 1'b0)      begin n_fail++; $display("FAIL mid_pending: got in_ready %b want 0", in_ready); end
        nRST = 1'b0;
        #1;
        n_checks += 5;
        if (out_valid !== 1'b0)     begin n_fail++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        if (out_bit !== c_BIT_RST)  begin n_fail++; $display("FAIL mid_out_bit: got %b want %b", out_bit, c_BIT_RST); end
        if (out_is_stuff !== 1'b0)  begin n_fail++; $display("FAIL mid_is_stuff: got %b want 0", out_is_stuff); end
        if (stuff_cnt !== 8'd0)     begin n_fail++; $display("FAIL mid_stuff_cnt: got %0d want 0", stuff_cnt); end
        if (in_ready !== 1'b1)      begin n_fail++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        nRST = 1'b1;
        drive(7, 32'h3F, 32'h40, 1'b0);
        exp_d = exp_line(32'h3F, 32'h80, 8);
        n_checks += 4;
        if (cap_n !== 8)            begin n_fail++; $display("FAIL mid2_count: got %0d want 8", cap_n); end
        if (cap_data !== exp_d)     begin n_fail++; $display("FAIL mid2_data: got %h want %h", cap_data, exp_d); end
        if (cap_stuff !== 32'h40)   begin n_fail++; $display("FAIL mid2_stuff: got %h want 40", cap_stuff); end
        if (stuff_cnt !== 8'd1)     begin n_fail++; $display("FAIL mid2_stuff_cnt: got %0d want 1", stuff_cnt); end
    endtask

`ifdef BIT_STUFFER_STREAM_NRZI_EN
    task automatic test_nrzi();
        drive(4, 32'h6, 32'h8, 1'b0);
        n_checks++;
        if (cap_data !== 32'h8)     begin n_fail++; $display("FAIL nrzi_levels: got %h want 8", cap_data); end
        drive(3, 32'h6, 32'h4, 1'b0);
        n_checks++;
        if (cap_data !== 32'h0)     begin n_fail++; $display("FAIL nrzi_levels2: got %h want 0", cap_data); end
        drive(1, 32'h1, 32'h1, 1'b0);
        n_checks++;
        if (cap_data !== 32'h1)     begin n_fail++; $display("FAIL nrzi_idle_return: got %h want 1", cap_data); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_stuff();
        test_thirteen_ones();
        test_stuff_carries_last();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_packet();
`ifdef BIT_STUFFER_STREAM_NRZI_EN
        test_nrzi();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
